// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// Module      : seq_divider
// Description : Unsigned restoring divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int               CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_DIVIDE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_ge;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_dvd_nxt;
  logic             w_last;

  // Extra top bit makes the trial subtraction's sign directly visible.
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial   = w_shift - {2'b00, r_dvs};
  assign w_ge      = ~w_trial[WIDTH+1];
  assign w_rem_nxt = w_ge ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
  assign w_dvd_nxt = (r_dvd << 1) | WIDTH'(w_ge);
  assign w_last    = (r_cnt == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   w_next = (r_dvs == '0) ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (w_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd <= A;
            r_dvs <= B;
            r_rem <= '0;
            r_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (r_dvs == '0) begin
            r_q   <= '1;
            r_r   <= r_dvd;
            r_dbz <= 1'b1;
          end else begin
            r_cnt <= '0;
            r_dbz <= 1'b0;
          end
        end
        S_DIVIDE: begin
          r_dvd <= w_dvd_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          // Results are published only on the final step so Q/R hold meanwhile.
          if (w_last) begin
            r_q <= w_dvd_nxt;
            r_r <= w_rem_nxt[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dbz;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//------------------------------------------------------------------------------
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider against an arithmetic model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

  localparam int             W    = 24;
  localparam logic [W-1:0]   ONES = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         busy;
  logic         done;
  logic         dbz;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q;
  logic [W-1:0] exp_r;
  logic         exp_dbz;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (dbz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result straight from the arithmetic definition.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) begin
      exp_q   = ONES;
      exp_r   = a;
      exp_dbz = 1'b1;
    end else begin
      exp_q   = a / b;
      exp_r   = a % b;
      exp_dbz = 1'b0;
    end
  endtask

  task automatic idle_step();
    @(posedge clk); #1;
    check("done_width", {31'd0, done}, 32'd0);
    check("idle_busy",  {31'd0, busy}, 32'd0);
    check("q_hold",     {8'd0, Q}, {8'd0, exp_q});
    check("r_hold",     {8'd0, R}, {8'd0, exp_r});
    check("dbz_hold",   {31'd0, dbz}, {31'd0, exp_dbz});
  endtask

  // Entered either in IDLE or in the done cycle of the previous division;
  // returns in the done cycle of this one.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit from_done, input bit inject);
    int n;
    bit got;
    start = 1'b1;
    A     = a;
    B     = b;
    if (from_done) idle_step();
    model(a, b);
    @(posedge clk); #1;
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    check("accept_busy", {31'd0, busy}, 32'd1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      if (inject && n == 5) begin
        start = 1'b1;
        A     = W'(9);
        B     = W'(9);
      end
      if (inject && n == 6) start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
    end
    check("done_seen", {31'd0, got}, 32'd1);
    check("latency",   n, (b == '0) ? 1 : W + 1);
    check("q",         {8'd0, Q}, {8'd0, exp_q});
    check("r",         {8'd0, R}, {8'd0, exp_r});
    check("dbz",       {31'd0, dbz}, {31'd0, exp_dbz});
    check("done_busy", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           saw;

    rst   = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #2 rst = 1'b1;
    #1;
    exp_q   = '0;
    exp_r   = '0;
    exp_dbz = 1'b0;
    check("rst_q",    {8'd0, Q}, 32'd0);
    check("rst_r",    {8'd0, R}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz",  {31'd0, dbz}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    run_div(W'(100), W'(7), 1'b0, 1'b0);
    run_div(ONES, W'(1), 1'b1, 1'b0);
    idle_step();
    run_div(W'(5), W'(9), 1'b0, 1'b0);
    idle_step();
    run_div(W'(1234), W'(0), 1'b0, 1'b0);
    idle_step();
    run_div(W'(1000), W'(3), 1'b0, 1'b1);
    idle_step();

    // Abort in the middle of DIVIDE with an asynchronous reset.
    start = 1'b1;
    A     = W'(777);
    B     = W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_q",    {8'd0, Q}, 32'd0);
    check("abort_r",    {8'd0, R}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_dbz",  {31'd0, dbz}, 32'd0);
    @(posedge clk); #1;
    rst     = 1'b0;
    exp_q   = '0;
    exp_r   = '0;
    exp_dbz = 1'b0;
    saw     = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    check("abort_no_done", {31'd0, saw}, 32'd0);
    run_div(W'(50), W'(5), 1'b0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      a = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = a >> 16;
      case ($urandom_range(0, 3))
        0:       b = W'($urandom_range(1, 16));
        1:       b = W'($urandom) >> $urandom_range(0, 23);
        default: b = W'($urandom);
      endcase
      if (b == '0) b = W'(1);
      run_div(a, b, 1'b1, 1'b0);
    end
    idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
